// File: rtl/hlcp_clk_detect.sv
// HLCP receive-side link clock detector: synchronizes clk_in, emits edge strobes,
// measures the rise-to-rise period and tracks lock / loss of lock.
`timescale 1ns / 1ps

module hlcp_clk_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned TOL         = 1,
  parameter int unsigned LOCK_CNT    = 4
) (
  input  logic             sys_clk,
  input  logic             sys_resetb,
  input  logic             core_en,
  input  logic             clk_in,
  output logic             clk_r,
  output logic             clk_f,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0]  TolX  = (CNT_W + 1)'(TOL);
  localparam logic [MW-1:0]   LockM = MW'(LOCK_CNT);

  typedef enum logic [1:0] {StIdle, StAcq, StMeas, StLocked} state_e;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_ref;
  logic [CNT_W-1:0]       r_period;
  logic [MW-1:0]          r_match;
  logic                   r_seen;
  logic                   r_locked;
  logic                   r_lost;
  state_e                 r_state;

  logic                   w_rise;
  logic                   w_fall;
  logic                   w_sat;
  logic                   w_in_tol;
  logic                   w_timeout;
  logic [CNT_W:0]         w_cnt_x;
  logic [CNT_W:0]         w_ref_x;
  logic [CNT_W:0]         w_diff;
  logic [MW-1:0]          w_match_inc;

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_fall = ~r_sync[SYNC_STAGES-1] & r_hist;
  assign w_sat  = &r_cnt;

  // One extra bit so |cnt-ref| and ref+TOL never wrap.
  assign w_cnt_x     = {1'b0, r_cnt};
  assign w_ref_x     = {1'b0, r_ref};
  assign w_diff      = (w_cnt_x >= w_ref_x) ? (w_cnt_x - w_ref_x) : (w_ref_x - w_cnt_x);
  assign w_in_tol    = (w_diff <= TolX);
  assign w_timeout   = (w_cnt_x > (w_ref_x + TolX));
  assign w_match_inc = r_match + 1'b1;

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CNT_W'(1);
    end else if (!w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_resetb) begin
    if (!sys_resetb) begin
      r_state  <= StIdle;
      r_ref    <= '0;
      r_period <= '0;
      r_match  <= '0;
      r_seen   <= 1'b0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      if (!core_en) begin
        r_state  <= StIdle;
        r_period <= '0;
        r_match  <= '0;
        r_seen   <= 1'b0;
        r_locked <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_state <= StAcq;
            r_seen  <= 1'b0;
          end
          StAcq: begin
            if (w_rise) begin
              if (!r_seen) begin
                r_seen <= 1'b1;
              end else begin
                r_ref   <= r_cnt;
                r_match <= '0;
                r_state <= StMeas;
              end
            end
          end
          StMeas: begin
            if (w_rise) begin
              if (w_in_tol) begin
                r_match <= w_match_inc;
                if (w_match_inc == LockM) begin
                  r_state  <= StLocked;
                  r_period <= r_cnt;
                  r_locked <= 1'b1;
                end
              end else begin
                r_ref   <= r_cnt;
                r_match <= '0;
              end
            end else if (w_sat) begin
              r_state <= StAcq;
              r_seen  <= 1'b0;
            end
          end
          StLocked: begin
            // A rise takes priority over the timeout; an out-of-tolerance rise
            // is reused as the first acquisition rise.
            if (w_rise) begin
              if (w_in_tol) begin
                r_period <= r_cnt;
              end else begin
                r_state  <= StAcq;
                r_seen   <= 1'b1;
                r_locked <= 1'b0;
                r_lost   <= 1'b1;
              end
            end else if (w_timeout) begin
              r_state  <= StAcq;
              r_seen   <= 1'b0;
              r_locked <= 1'b0;
              r_lost   <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign clk_r  = core_en & w_rise;
  assign clk_f  = core_en & w_fall;
  assign period = r_period;
  assign locked = r_locked;
  assign lost   = r_lost;

endmodule

// File: tb/tb_hlcp_clk_detect.sv
// Bench for hlcp_clk_detect: strobe and lost timings are queued when clk_in is
// driven and compared when the DUT produces them; lock state checked at fixed points.
`timescale 1ns / 1ps

module tb_hlcp_clk_detect;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned TOL   = 1;

  logic             sys_clk = 1'b0;
  logic             sys_resetb;
  logic             core_en;
  logic             clk_in;
  logic             clk_r;
  logic             clk_f;
  logic [CNT_W-1:0] period;
  logic             locked;
  logic             lost;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          chk_lock_cyc = -1;
  int          q_rise[$];
  int          q_fall[$];
  int          q_lost[$];

  hlcp_clk_detect #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (CNT_W),
    .TOL        (TOL),
    .LOCK_CNT   (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_resetb(sys_resetb),
    .core_en   (core_en),
    .clk_in    (clk_in),
    .clk_r     (clk_r),
    .clk_f     (clk_f),
    .period    (period),
    .locked    (locked),
    .lost      (lost)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // First sampled at the next edge, strobe visible SYNC cycles after the drive.
  task automatic set_clk(input logic v);
    if (v !== clk_in && core_en) begin
      if (v) q_rise.push_back(cyc + SYNC);
      else   q_fall.push_back(cyc + SYNC);
    end
    clk_in = v;
  endtask

  task automatic drive_period(input int hi, input int lo);
    step();
    set_clk(1'b1);
    repeat (hi - 1) step();
    step();
    set_clk(1'b0);
    repeat (lo - 1) step();
  endtask

  task automatic check_outs(input string tag, input logic exp_locked,
                            input logic [CNT_W-1:0] exp_period);
    check({tag, "_locked"}, {31'b0, locked}, {31'b0, exp_locked});
    check({tag, "_period"}, {22'b0, period}, {22'b0, exp_period});
  endtask

  always @(negedge sys_clk) begin
    if (q_rise.size() > 0 && q_rise[0] == cyc) begin
      check("clk_r", {31'b0, clk_r}, 32'd1);
      void'(q_rise.pop_front());
    end else if (clk_r) begin
      check("clk_r_unexp", {31'b0, clk_r}, 32'd0);
    end
    if (q_fall.size() > 0 && q_fall[0] == cyc) begin
      check("clk_f", {31'b0, clk_f}, 32'd1);
      void'(q_fall.pop_front());
    end else if (clk_f) begin
      check("clk_f_unexp", {31'b0, clk_f}, 32'd0);
    end
    if (q_lost.size() > 0 && q_lost[0] == cyc) begin
      check("lost", {31'b0, lost}, 32'd1);
      void'(q_lost.pop_front());
    end else if (lost) begin
      check("lost_unexp", {31'b0, lost}, 32'd0);
    end
    if (chk_lock_cyc >= 0 && cyc == chk_lock_cyc - 1)
      check("lock_early", {31'b0, locked}, 32'd0);
    if (chk_lock_cyc >= 0 && cyc == chk_lock_cyc) begin
      check("lock_time", {31'b0, locked}, 32'd1);
      check("lock_period", {22'b0, period}, 32'd8);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tol_len[5] = '{7, 9, 7, 9, 10};
    int prev;

    sys_resetb = 1'b0;
    core_en    = 1'b0;
    clk_in     = 1'b0;
    repeat (3) step();
    check("rst_clk_r", {31'b0, clk_r}, 32'd0);
    check("rst_clk_f", {31'b0, clk_f}, 32'd0);
    check("rst_lost", {31'b0, lost}, 32'd0);
    check_outs("rst", 1'b0, '0);
    sys_resetb = 1'b1;
    repeat (2) step();

    // Disabled: no strobes, no lock while clk_in toggles.
    repeat (4) drive_period(4, 4);
    repeat (3) step();
    check_outs("idle", 1'b0, '0);

    // Acquisition at period 8: 2 acquisition rises + 4 matches.
    core_en = 1'b1;
    repeat (3) step();
    chk_lock_cyc = cyc + 1 + SYNC + 5 * 8 + 1;
    repeat (6) drive_period(4, 4);
    check_outs("acq", 1'b1, 10'd8);
    chk_lock_cyc = -1;

    // Tolerance: each rise reports the length of the preceding period.
    prev = 8;
    foreach (tol_len[i]) begin
      drive_period(tol_len[i] - tol_len[i] / 2, tol_len[i] / 2);
      check_outs("tol", 1'b1, 10'(prev));
      prev = tol_len[i];
    end
    q_lost.push_back(cyc + 1 + SYNC + 1);
    drive_period(4, 4);
    check_outs("tol_lost", 1'b0, 10'd9);
    // The rise that broke lock is the first acquisition rise.
    repeat (4) drive_period(4, 4);
    check_outs("relock_pre", 1'b0, 10'd9);
    drive_period(4, 4);
    check_outs("relock", 1'b1, 10'd8);

    // Timeout: clk_in stuck high after an in-tolerance rise.
    step();
    set_clk(1'b1);
    q_lost.push_back(cyc + SYNC + 8 + TOL + 2);
    repeat (20) step();
    check_outs("timeout", 1'b0, 10'd8);

    // Divider loopback model: half-period 8, then half-period 2.
    step();
    set_clk(1'b0);
    repeat (4) step();
    repeat (6) drive_period(8, 8);
    check_outs("div16", 1'b1, 10'd16);
    drive_period(2, 2);
    check_outs("div_chg", 1'b1, 10'd16);
    q_lost.push_back(cyc + 1 + SYNC + 1);
    drive_period(2, 2);
    check_outs("div_lost", 1'b0, 10'd16);
    repeat (6) drive_period(2, 2);
    check_outs("div4", 1'b1, 10'd4);

    // Disable on the very cycle the rise strobe would appear.
    step();
    clk_in = 1'b1;
    repeat (SYNC) step();
    core_en = 1'b0;
    step();
    check_outs("dis", 1'b0, '0);
    step();
    clk_in = 1'b0;
    repeat (4) step();
    core_en = 1'b1;
    repeat (3) step();
    repeat (5) drive_period(4, 4);
    check_outs("reen_pre", 1'b0, '0);
    drive_period(4, 4);
    check_outs("reen", 1'b1, 10'd8);

    // Asynchronous reset while locked.
    step();
    sys_resetb = 1'b0;
    #1;
    check("arst_clk_r", {31'b0, clk_r}, 32'd0);
    check("arst_clk_f", {31'b0, clk_f}, 32'd0);
    check("arst_lost", {31'b0, lost}, 32'd0);
    check_outs("arst", 1'b0, '0);
    repeat (2) step();
    sys_resetb = 1'b1;
    repeat (4) step();
    check_outs("post_rst", 1'b0, '0);
    check("q_empty", q_rise.size() + q_fall.size() + q_lost.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
